// File: rtl/pc_fetch_ctrl.sv
// Fetch PC generator and IF segment-register driver: sequential fetch, I-cache miss wait,
// hazard stalls and redirects, with redirects seen during a miss deferred until the refill.
// Optional performance counters are enabled by defining PC_FETCH_PERF_CNT_EN.
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_in,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        icache_miss,
    output logic        fetch_req,
    output logic [31:0] fetch_pc,
    output logic [31:0] if_pc,
    output logic        if_en,
    output logic        if_flush,
`ifdef PC_FETCH_PERF_CNT_EN
    output logic [31:0] miss_cycles,
    output logic [31:0] redirect_cnt,
`endif
    output logic        busy
);

    localparam int unsigned PC_W = 32;

    typedef enum logic {RUN, MISS_WAIT} state_t;

    state_t          state, state_nxt;
    logic [PC_W-1:0] pc_reg, pc_nxt;
    logic            pend_valid, pend_valid_nxt;
    logic [PC_W-1:0] pend_pc, pend_pc_nxt;
    logic            en_nxt, flush_nxt;
    logic [PC_W-1:0] redir_aligned;
    logic [PC_W-1:0] pc_inc;

    assign redir_aligned = {redirect_pc[31:2], 2'b00};
    assign pc_inc        = pc_reg + PC_W'(PC_STEP);

    // Next-state decision; priority redirect > miss > stall > advance
    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc_reg;
        pend_valid_nxt = pend_valid;
        pend_pc_nxt    = pend_pc;
        en_nxt         = 1'b0;
        flush_nxt      = 1'b0;
        case (state)
            RUN: begin
                if (redirect_valid) begin
                    pc_nxt    = redir_aligned;
                    flush_nxt = 1'b1;
                end else if (icache_miss) begin
                    state_nxt = MISS_WAIT;
                end else if (!stall_in) begin
                    en_nxt = 1'b1;
                    pc_nxt = pc_inc;
                end
            end
            MISS_WAIT: begin
                if (icache_miss) begin
                    if (redirect_valid) begin
                        pend_valid_nxt = 1'b1;
                        pend_pc_nxt    = redir_aligned;
                    end
                end else begin
                    state_nxt      = RUN;
                    pend_valid_nxt = 1'b0;
                    if (redirect_valid) begin
                        pc_nxt    = redir_aligned;
                        flush_nxt = 1'b1;
                    end else if (pend_valid) begin
                        pc_nxt    = pend_pc;
                        flush_nxt = 1'b1;
                    end else if (!stall_in) begin
                        en_nxt = 1'b1;
                        pc_nxt = pc_inc;
                    end
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            pc_reg     <= RESET_PC;
            pend_valid <= 1'b0;
            pend_pc    <= '0;
        end else begin
            state      <= state_nxt;
            pc_reg     <= pc_nxt;
            pend_valid <= pend_valid_nxt;
            pend_pc    <= pend_pc_nxt;
        end
    end

    assign fetch_pc  = pc_reg;
    assign if_pc     = pc_reg;
    assign fetch_req = !rst;
    assign if_en     = !rst && en_nxt;
    assign if_flush  = !rst && flush_nxt;
    assign busy      = !rst && (state == MISS_WAIT);

`ifdef PC_FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            miss_cycles  <= '0;
            redirect_cnt <= '0;
        end else begin
            if (state == MISS_WAIT) miss_cycles <= miss_cycles + 32'd1;
            if (if_flush)           redirect_cnt <= redirect_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Table-driven bench for pc_fetch_ctrl; expected outputs per cycle are queued at drive
// time and popped at the falling edge when the combinational outputs are sampled.
module tb_pc_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst, stall_in, redirect_valid, icache_miss;
    logic [31:0] redirect_pc;
    logic        fetch_req, if_en, if_flush, busy;
    logic [31:0] fetch_pc, if_pc;
`ifdef PC_FETCH_PERF_CNT_EN
    logic [31:0] miss_cycles, redirect_cnt;
`endif

    pc_fetch_ctrl dut (
        .clk(clk), .rst(rst), .stall_in(stall_in), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .icache_miss(icache_miss), .fetch_req(fetch_req),
        .fetch_pc(fetch_pc), .if_pc(if_pc), .if_en(if_en), .if_flush(if_flush),
`ifdef PC_FETCH_PERF_CNT_EN
        .miss_cycles(miss_cycles), .redirect_cnt(redirect_cnt),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, stall, redir;
        logic [31:0] rpc;
        logic        miss;
        logic [31:0] pc;
        logic        req, en, fl, bsy;
    } vec_t;

    localparam int NV = 34;
    vec_t tbl[NV];
    vec_t sb_q[$];
    int   errors = 0;
    int   checks = 0;

    function automatic vec_t v(logic r, logic s, logic rd, logic [31:0] rp, logic m,
                               logic [31:0] pc, logic rq, logic en, logic fl, logic b);
        vec_t x;
        x.rst = r; x.stall = s; x.redir = rd; x.rpc = rp; x.miss = m;
        x.pc = pc; x.req = rq; x.en = en; x.fl = fl; x.bsy = b;
        return x;
    endfunction

    task automatic chk(string name, int row, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL row%0d %s: got %h expected %h", row, name, act, exp);
        end
    endtask

    initial begin
        //           rst st rd rpc           miss pc            req en fl busy
        tbl[0]  = v(1, 0, 0, 32'h0,        0, 32'h0,        0, 0, 0, 0);
        tbl[1]  = v(0, 0, 0, 32'h0,        0, 32'h0,        1, 1, 0, 0);
        tbl[2]  = v(0, 0, 0, 32'h0,        0, 32'h4,        1, 1, 0, 0);
        tbl[3]  = v(0, 1, 0, 32'h0,        0, 32'h8,        1, 0, 0, 0);
        tbl[4]  = v(0, 1, 0, 32'h0,        0, 32'h8,        1, 0, 0, 0);
        tbl[5]  = v(0, 0, 0, 32'h0,        0, 32'h8,        1, 1, 0, 0);
        tbl[6]  = v(0, 0, 0, 32'h0,        0, 32'hC,        1, 1, 0, 0);
        tbl[7]  = v(0, 0, 1, 32'h103,      0, 32'h10,       1, 0, 1, 0);
        tbl[8]  = v(0, 0, 0, 32'h0,        0, 32'h100,      1, 1, 0, 0);
        tbl[9]  = v(0, 0, 1, 32'h20,       0, 32'h104,      1, 0, 1, 0);
        tbl[10] = v(0, 0, 0, 32'h0,        1, 32'h20,       1, 0, 0, 0);
        tbl[11] = v(0, 0, 1, 32'h200,      1, 32'h20,       1, 0, 0, 1);
        tbl[12] = v(0, 0, 0, 32'h0,        1, 32'h20,       1, 0, 0, 1);
        tbl[13] = v(0, 0, 0, 32'h0,        0, 32'h20,       1, 0, 1, 1);
        tbl[14] = v(0, 0, 0, 32'h0,        0, 32'h200,      1, 1, 0, 0);
        tbl[15] = v(0, 0, 1, 32'hFFFFFFFF, 0, 32'h204,      1, 0, 1, 0);
        tbl[16] = v(0, 0, 0, 32'h0,        0, 32'hFFFFFFFC, 1, 1, 0, 0);
        tbl[17] = v(0, 0, 0, 32'h0,        0, 32'h0,        1, 1, 0, 0);
        tbl[18] = v(0, 1, 1, 32'h40,       1, 32'h4,        1, 0, 1, 0);
        tbl[19] = v(0, 0, 0, 32'h0,        1, 32'h40,       1, 0, 0, 0);
        tbl[20] = v(0, 1, 0, 32'h0,        0, 32'h40,       1, 0, 0, 1);
        tbl[21] = v(0, 0, 0, 32'h0,        0, 32'h40,       1, 1, 0, 0);
        tbl[22] = v(0, 0, 0, 32'h0,        1, 32'h44,       1, 0, 0, 0);
        tbl[23] = v(0, 0, 1, 32'h300,      1, 32'h44,       1, 0, 0, 1);
        tbl[24] = v(0, 0, 1, 32'h402,      0, 32'h44,       1, 0, 1, 1);
        tbl[25] = v(0, 0, 0, 32'h0,        0, 32'h400,      1, 1, 0, 0);
        tbl[26] = v(0, 0, 0, 32'h0,        1, 32'h404,      1, 0, 0, 0);
        tbl[27] = v(0, 0, 0, 32'h0,        0, 32'h404,      1, 1, 0, 1);
        tbl[28] = v(0, 0, 0, 32'h0,        1, 32'h408,      1, 0, 0, 0);
        tbl[29] = v(0, 0, 1, 32'h500,      1, 32'h408,      1, 0, 0, 1);
        tbl[30] = v(1, 0, 0, 32'h0,        1, 32'h408,      0, 0, 0, 0);
        tbl[31] = v(0, 0, 0, 32'h0,        1, 32'h0,        1, 0, 0, 0);
        tbl[32] = v(0, 0, 0, 32'h0,        0, 32'h0,        1, 1, 0, 1);
        tbl[33] = v(0, 0, 0, 32'h0,        0, 32'h4,        1, 1, 0, 0);

        rst = 1'b1; stall_in = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; icache_miss = 1'b0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < NV; i++) begin
            vec_t e;
            #1;
            rst = tbl[i].rst; stall_in = tbl[i].stall; redirect_valid = tbl[i].redir;
            redirect_pc = tbl[i].rpc; icache_miss = tbl[i].miss;
            sb_q.push_back(tbl[i]);
            @(negedge clk);
            e = sb_q.pop_front();
            chk("fetch_pc",  i, fetch_pc, e.pc);
            chk("if_pc",     i, if_pc, e.pc);
            chk("fetch_req", i, 32'(fetch_req), 32'(e.req));
            chk("if_en",     i, 32'(if_en), 32'(e.en));
            chk("if_flush",  i, 32'(if_flush), 32'(e.fl));
            chk("busy",      i, 32'(busy), 32'(e.bsy));
`ifdef PC_FETCH_PERF_CNT_EN
            if (i == 31) begin
                chk("miss_cycles_after_rst",  i, miss_cycles, 32'd0);
                chk("redirect_cnt_after_rst", i, redirect_cnt, 32'd0);
            end
            if (i == 33) begin
                chk("miss_cycles_end",  i, miss_cycles, 32'd1);
                chk("redirect_cnt_end", i, redirect_cnt, 32'd0);
            end
`endif
            @(posedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
- Producer end of the IF segment-register interface: generates the fetch PC, drives the IF segment register's PC input and enable, and issues instruction-cache lookups.
- Tracks sequential fetch, I-cache miss stalls, downstream hazard stalls and branch/jump redirects, including redirects that arrive during a miss.
- Sits between the branch/hazard unit and the IF segment register / instruction cache.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset; low 2 bits must be 0.
- PC_STEP, 4, sequential increment in bytes.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- stall_in  in  1  downstream hazard stall; hold the PC, do not load the IF segment register.
- redirect_valid  in  1  branch/jump taken this cycle.
- redirect_pc  in  32  redirect target; bits [1:0] are ignored and forced to 0.
- icache_miss  in  1  I-cache reports a miss on the current fetch_pc; high until the refill completes.
- fetch_req  out  1  I-cache lookup request.
- fetch_pc  out  32  address being fetched; equals the internal pc_reg.
- if_pc  out  32  value for the IF segment register's PC input; equals fetch_pc.
- if_en  out  1  IF segment register load enable.
- if_flush  out  1  one-cycle pulse; downstream squashes the instruction in IF.
- busy  out  1  high in MISS_WAIT.

Behaviour:
- Internal registers:
  - pc_reg[31:0]
  - state: RUN or MISS_WAIT
  - pend_valid, pend_pc[31:0] (redirect captured during a miss)
- Reset (rst high at a clock edge):
  - pc_reg=RESET_PC, state=RUN, pend_valid=0, pend_pc=0.
  - While rst is high: fetch_req=0, if_en=0, if_flush=0, busy=0.
  - Reset mid-miss discards pend and returns to RUN.
- Outputs are combinational from the registers and current inputs:
  - fetch_pc=if_pc=pc_reg.
  - fetch_req=1 whenever rst=0.
- RUN state, priority redirect > miss > stall > advance:
  - redirect_valid=1: pc_reg<={redirect_pc[31:2],2'b00}; if_flush=1; if_en=0; stay in RUN. Miss and stall are ignored that cycle.
  - else icache_miss=1: if_en=0; pc_reg holds; next state=MISS_WAIT.
  - else stall_in=1: if_en=0; pc_reg holds.
  - else: if_en=1; pc_reg<=pc_reg+PC_STEP (mod 2^32; 32'hFFFF_FFFC wraps to 0).
- MISS_WAIT state:
  - busy=1; if_en=0; fetch_pc held.
  - redirect_valid=1: pend_valid<=1; pend_pc<=aligned redirect_pc. A later redirect overwrites an earlier one. No flush yet.
  - icache_miss=1: stay in MISS_WAIT.
  - icache_miss=0 (refill done), next state=RUN, with the sub-cases below evaluated in order:
    - redirect_valid=1 this same cycle: that redirect wins over pend; apply the RUN redirect action; clear pend_valid.
    - else pend_valid=1: pc_reg<=pend_pc; if_flush=1; if_en=0; pend_valid<=0.
    - else stall_in=1: hold pc_reg; if_en=0.
    - else: if_en=1; pc_reg<=pc_reg+PC_STEP.
- Latency:
  - A redirect is visible on fetch_pc the cycle after it is asserted in RUN.
  - A deferred redirect is visible the cycle after icache_miss falls.
- Invariant: if_en and if_flush are never both 1.

Optional Feature:
- Macro: PC_FETCH_PERF_CNT_EN.
- Defined:
  - Adds outputs miss_cycles[31:0] and redirect_cnt[31:0], both cleared by rst.
  - miss_cycles increments every cycle state==MISS_WAIT.
  - redirect_cnt increments every cycle the block drives if_flush=1.
  - Both wrap at 2^32.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then 4 idle cycles with no stall/miss/redirect -> fetch_pc 0x0,0x4,0x8,0xC; if_en=1 each cycle; if_flush=0.
- At pc=0x8 assert stall_in for 2 cycles -> fetch_pc stays 0x8; if_en=0 for 2 cycles; then 0xC with if_en=1.
- At pc=0x10 assert redirect_valid with redirect_pc=0x0000_0103 -> if_flush=1 for one cycle; next fetch_pc=0x100.
- At pc=0x20 icache_miss high for 3 cycles; redirect_pc=0x200 pulsed in the 2nd miss cycle -> busy=1, if_en=0 throughout; on the miss-clear cycle if_flush=1; next fetch_pc=0x200; no advance to 0x24.
- Force pc=0xFFFF_FFFC via redirect, then advance -> next fetch_pc=0x0000_0000.
- Assert rst during MISS_WAIT with pend_valid set -> next cycle fetch_pc=RESET_PC, busy=0, no flush. With the macro defined, miss_cycles and redirect_cnt read 0.
